// File: rtl/vector_cache_pkg.sv
// Shared constants, the local read command record and the parity helper for the vector cache SRAM chain.
package vector_cache_pkg;

    localparam int VC_LANES  = 8;
    localparam int VC_DATA_W = 32;
    localparam int VC_ADDR_W = 8;
    localparam int VC_BLK_W  = 4;
    localparam int VC_TAG_W  = 12;
    localparam int PAR_MAX_W = 256;

    typedef struct packed {
        logic [VC_ADDR_W-1:0] addr;
        logic [VC_TAG_W-1:0]  tag;
    } sram_inst_cmd_t;

    // Even parity bit: XOR of the word, so word plus parity always XORs to zero.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/vec_cache_rd_skid.sv
// One lane's return path: tag pipeline, credit counter, skid FIFO and return-ring slot mux.
module vec_cache_rd_skid #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 12,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_vld_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic              wr_hit_d1_i,
    output logic              rdy_o,
    output logic              accept_o,
    input  logic [DATA_W-1:0] sram_data_i,
    input  logic              sram_err_i,
    input  logic              up_vld_i,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [TAG_W-1:0]  up_tag_i,
    input  logic              up_err_i,
    output logic              out_vld_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              out_err_o
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [RD_LAT-1:0] vld_pipe_q;
    logic [TAG_W-1:0]  tag_pipe_q [RD_LAT];
    logic [CNT_W-1:0]  inflight_q, inflight_d, occ_q, occ_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W:0]    credit_sum;
    logic [DATA_W-1:0] fifo_data_q [SKID_DEPTH];
    logic [TAG_W-1:0]  fifo_tag_q  [SKID_DEPTH];
    logic              fifo_err_q  [SKID_DEPTH];
    logic              ret_vld, fifo_empty, pop, bypass, push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover both outstanding SRAM reads and queued data, so a push never finds the FIFO full.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, occ_q};
    assign rdy_o      = (credit_sum < (CNT_W+1)'(SKID_DEPTH)) && !wr_hit_d1_i;
    assign accept_o   = rd_vld_i && rdy_o;

    assign ret_vld    = vld_pipe_q[RD_LAT-1];
    assign fifo_empty = (occ_q == '0);
    assign pop        = !up_vld_i && !fifo_empty;
    assign bypass     = !up_vld_i && fifo_empty && ret_vld;
    assign push       = ret_vld && !bypass;

    always_comb begin
        inflight_d = inflight_q + CNT_W'(accept_o) - CNT_W'(ret_vld);
        occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            vld_pipe_q[0] <= accept_o;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
            end
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_pipe_q[0] <= rd_tag_i;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_pipe_q[k] <= tag_pipe_q[k-1];
        end
        if (push) begin
            fifo_data_q[wr_ptr_q] <= sram_data_i;
            fifo_tag_q[wr_ptr_q]  <= tag_pipe_q[RD_LAT-1];
            fifo_err_q[wr_ptr_q]  <= sram_err_i;
        end
    end

    // Upstream owns the slot; otherwise the oldest queued word goes first, then fresh SRAM data.
    always_comb begin
        out_vld_o  = up_vld_i;
        out_data_o = up_data_i;
        out_tag_o  = up_tag_i;
        out_err_o  = up_err_i;
        if (!up_vld_i) begin
            if (!fifo_empty) begin
                out_vld_o  = 1'b1;
                out_data_o = fifo_data_q[rd_ptr_q];
                out_tag_o  = fifo_tag_q[rd_ptr_q];
                out_err_o  = fifo_err_q[rd_ptr_q];
            end else if (ret_vld) begin
                out_vld_o  = 1'b1;
                out_data_o = sram_data_i;
                out_tag_o  = tag_pipe_q[RD_LAT-1];
                out_err_o  = sram_err_i;
            end
        end
    end

endmodule

// File: rtl/vec_cache_sram_sp.sv
// Single-port SRAM model; read data appears RD_LAT cycles after a read-enabled cycle.
module vec_cache_sram_sp #(
    parameter int WIDTH  = 32,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q     [2**AW];
    logic [WIDTH-1:0] rd_pipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (en_i && !we_i) begin
            rd_pipe_q[0] <= mem_q[addr_i];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            rd_pipe_q[k] <= rd_pipe_q[k-1];
        end
    end

    assign rdata_o = rd_pipe_q[RD_LAT-1];

endmodule

// File: rtl/vec_cache_mem_block_p.sv
// Vector cache memory block: per-lane SRAM, command forwarding and return-ring injection.
// Optional SRAM parity checking is enabled by defining VEC_CACHE_MEM_PARITY_EN.
module vec_cache_mem_block_p
    import vector_cache_pkg::*;
#(
    parameter int BLOCK_ID   = 0,
    parameter int LANES      = VC_LANES,
    parameter int DATA_W     = VC_DATA_W,
    parameter int ADDR_W     = VC_ADDR_W,
    parameter int BLK_W      = VC_BLK_W,
    parameter int TAG_W      = VC_TAG_W,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        west_rd_vld_in,
    input  logic [LANES*ADDR_W-1:0] west_rd_addr_in,
    input  logic [LANES*BLK_W-1:0]  west_rd_blk_in,
    input  logic [LANES*TAG_W-1:0]  west_rd_tag_in,
    output logic [LANES-1:0]        west_rd_rdy_out,
    output logic [LANES-1:0]        east_rd_vld_out,
    output logic [LANES*ADDR_W-1:0] east_rd_addr_out,
    output logic [LANES*BLK_W-1:0]  east_rd_blk_out,
    output logic [LANES*TAG_W-1:0]  east_rd_tag_out,
    input  logic [LANES-1:0]        east_rd_rdy_in,
    input  logic [LANES-1:0]        east_wr_vld_in,
    input  logic [LANES*ADDR_W-1:0] east_wr_addr_in,
    input  logic [LANES*BLK_W-1:0]  east_wr_blk_in,
    output logic [LANES-1:0]        west_wr_vld_out,
    output logic [LANES*ADDR_W-1:0] west_wr_addr_out,
    output logic [LANES*BLK_W-1:0]  west_wr_blk_out,
    input  logic [LANES-1:0]        east_wdata_vld_in,
    input  logic [LANES*DATA_W-1:0] east_wdata_in,
    output logic [LANES-1:0]        west_wdata_vld_out,
    output logic [LANES*DATA_W-1:0] west_wdata_out,
    input  logic [LANES-1:0]        west_rdata_vld_in,
    input  logic [LANES*DATA_W-1:0] west_rdata_in,
    input  logic [LANES*TAG_W-1:0]  west_rtag_in,
    input  logic [LANES-1:0]        west_rerr_in,
    output logic [LANES-1:0]        east_rdata_vld_out,
    output logic [LANES*DATA_W-1:0] east_rdata_out,
    output logic [LANES*TAG_W-1:0]  east_rtag_out,
    output logic [LANES-1:0]        east_rerr_out,
    output logic [LANES-1:0]        par_err_out
);

`ifdef VEC_CACHE_MEM_PARITY_EN
    localparam int SRAM_W = DATA_W + 1;
`else
    localparam int SRAM_W = DATA_W;
`endif
    localparam logic [BLK_W-1:0] MY_BLK = BLK_W'(BLOCK_ID);

    assign east_rd_addr_out   = west_rd_addr_in;
    assign east_rd_blk_out    = west_rd_blk_in;
    assign east_rd_tag_out    = west_rd_tag_in;
    assign west_wr_addr_out   = east_wr_addr_in;
    assign west_wr_blk_out    = east_wr_blk_in;
    assign west_wdata_vld_out = east_wdata_vld_in;
    assign west_wdata_out     = east_wdata_in;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic              rd_hit, wr_hit, wr_hit_d1_q, skid_rdy, rd_accept, local_err;
        logic [ADDR_W-1:0] wr_addr_q, sram_addr;
        logic [DATA_W-1:0] wdata;
        logic [SRAM_W-1:0] sram_wdata, sram_rdata;

        assign rd_hit = (west_rd_blk_in[gi*BLK_W +: BLK_W] == MY_BLK);
        assign wr_hit = east_wr_vld_in[gi] && (east_wr_blk_in[gi*BLK_W +: BLK_W] == MY_BLK);

        assign east_rd_vld_out[gi] = west_rd_vld_in[gi] && !rd_hit;
        assign west_rd_rdy_out[gi] = rd_hit ? skid_rdy : east_rd_rdy_in[gi];
        assign west_wr_vld_out[gi] = east_wr_vld_in[gi] && !wr_hit;

        // Write data trails its command by one cycle, so the address is held until then.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_hit_d1_q <= 1'b0;
                wr_addr_q   <= '0;
            end else begin
                wr_hit_d1_q <= wr_hit;
                wr_addr_q   <= east_wr_addr_in[gi*ADDR_W +: ADDR_W];
            end
        end

        assign wdata     = east_wdata_in[gi*DATA_W +: DATA_W];
        assign sram_addr = wr_hit_d1_q ? wr_addr_q : west_rd_addr_in[gi*ADDR_W +: ADDR_W];

        vec_cache_sram_sp #(
            .WIDTH  (SRAM_W),
            .AW     (ADDR_W),
            .RD_LAT (RD_LAT)
        ) u_sram (
            .clk     (clk),
            .en_i    (rd_accept || wr_hit_d1_q),
            .we_i    (wr_hit_d1_q),
            .addr_i  (sram_addr),
            .wdata_i (sram_wdata),
            .rdata_o (sram_rdata)
        );

        vec_cache_rd_skid #(
            .DATA_W     (DATA_W),
            .TAG_W      (TAG_W),
            .RD_LAT     (RD_LAT),
            .SKID_DEPTH (SKID_DEPTH)
        ) u_skid (
            .clk         (clk),
            .rst         (rst),
            .rd_vld_i    (west_rd_vld_in[gi] && rd_hit),
            .rd_tag_i    (west_rd_tag_in[gi*TAG_W +: TAG_W]),
            .wr_hit_d1_i (wr_hit_d1_q),
            .rdy_o       (skid_rdy),
            .accept_o    (rd_accept),
            .sram_data_i (sram_rdata[DATA_W-1:0]),
            .sram_err_i  (local_err),
            .up_vld_i    (west_rdata_vld_in[gi]),
            .up_data_i   (west_rdata_in[gi*DATA_W +: DATA_W]),
            .up_tag_i    (west_rtag_in[gi*TAG_W +: TAG_W]),
            .up_err_i    (west_rerr_in[gi]),
            .out_vld_o   (east_rdata_vld_out[gi]),
            .out_data_o  (east_rdata_out[gi*DATA_W +: DATA_W]),
            .out_tag_o   (east_rtag_out[gi*TAG_W +: TAG_W]),
            .out_err_o   (east_rerr_out[gi])
        );

`ifdef VEC_CACHE_MEM_PARITY_EN
        logic par_err_q;

        assign sram_wdata = {even_parity(PAR_MAX_W'(wdata)), wdata};
        assign local_err  = even_parity(PAR_MAX_W'(sram_rdata[DATA_W-1:0])) != sram_rdata[DATA_W];

        // Sticky flag latches when a locally sourced word leaves with a parity error.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                par_err_q <= 1'b0;
            end else if (east_rdata_vld_out[gi] && !west_rdata_vld_in[gi] && east_rerr_out[gi]) begin
                par_err_q <= 1'b1;
            end
        end
        assign par_err_out[gi] = par_err_q;
`else
        assign sram_wdata      = wdata;
        assign local_err       = 1'b0;
        assign par_err_out[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_vec_cache_mem_block_p.sv
// Directed self-checking bench for vec_cache_mem_block_p (parity tests follow VEC_CACHE_MEM_PARITY_EN).
module tb_vec_cache_mem_block_p;

    localparam int BLOCK_ID   = 0;
    localparam int LANES      = 8;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int BLK_W      = 4;
    localparam int TAG_W      = 12;
    localparam int RD_LAT     = 1;
    localparam int SKID_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LANES-1:0]        west_rd_vld_in, west_rd_rdy_out, east_rd_vld_out, east_rd_rdy_in;
    logic [LANES*ADDR_W-1:0] west_rd_addr_in, east_rd_addr_out, east_wr_addr_in, west_wr_addr_out;
    logic [LANES*BLK_W-1:0]  west_rd_blk_in, east_rd_blk_out, east_wr_blk_in, west_wr_blk_out;
    logic [LANES*TAG_W-1:0]  west_rd_tag_in, east_rd_tag_out, west_rtag_in, east_rtag_out;
    logic [LANES-1:0]        east_wr_vld_in, west_wr_vld_out, east_wdata_vld_in, west_wdata_vld_out;
    logic [LANES*DATA_W-1:0] east_wdata_in, west_wdata_out, west_rdata_in, east_rdata_out;
    logic [LANES-1:0]        west_rdata_vld_in, west_rerr_in, east_rdata_vld_out, east_rerr_out, par_err_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vec_cache_mem_block_p #(
        .BLOCK_ID (BLOCK_ID), .LANES (LANES), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
        .BLK_W (BLK_W), .TAG_W (TAG_W), .RD_LAT (RD_LAT), .SKID_DEPTH (SKID_DEPTH)
    ) dut (
        .clk (clk), .rst (rst),
        .west_rd_vld_in (west_rd_vld_in), .west_rd_addr_in (west_rd_addr_in),
        .west_rd_blk_in (west_rd_blk_in), .west_rd_tag_in (west_rd_tag_in),
        .west_rd_rdy_out (west_rd_rdy_out),
        .east_rd_vld_out (east_rd_vld_out), .east_rd_addr_out (east_rd_addr_out),
        .east_rd_blk_out (east_rd_blk_out), .east_rd_tag_out (east_rd_tag_out),
        .east_rd_rdy_in (east_rd_rdy_in),
        .east_wr_vld_in (east_wr_vld_in), .east_wr_addr_in (east_wr_addr_in), .east_wr_blk_in (east_wr_blk_in),
        .west_wr_vld_out (west_wr_vld_out), .west_wr_addr_out (west_wr_addr_out), .west_wr_blk_out (west_wr_blk_out),
        .east_wdata_vld_in (east_wdata_vld_in), .east_wdata_in (east_wdata_in),
        .west_wdata_vld_out (west_wdata_vld_out), .west_wdata_out (west_wdata_out),
        .west_rdata_vld_in (west_rdata_vld_in), .west_rdata_in (west_rdata_in),
        .west_rtag_in (west_rtag_in), .west_rerr_in (west_rerr_in),
        .east_rdata_vld_out (east_rdata_vld_out), .east_rdata_out (east_rdata_out),
        .east_rtag_out (east_rtag_out), .east_rerr_out (east_rerr_out),
        .par_err_out (par_err_out)
    );

    // Skid FIFO must never be pushed while full.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mon
        always @(negedge clk) begin
            if (!rst && dut.g_lane[gi].u_skid.push && (dut.g_lane[gi].u_skid.occ_q == SKID_DEPTH)) begin
                errors++;
                $display("FAIL fifo_overflow lane %0d: push with occupancy %0d, required below %0d",
                         gi, dut.g_lane[gi].u_skid.occ_q, SKID_DEPTH);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000ns");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        west_rd_vld_in = '0; west_rd_addr_in = '0; west_rd_blk_in = '0; west_rd_tag_in = '0;
        east_rd_rdy_in = '1;
        east_wr_vld_in = '0; east_wr_addr_in = '0; east_wr_blk_in = '0;
        east_wdata_vld_in = '0; east_wdata_in = '0;
        west_rdata_vld_in = '0; west_rdata_in = '0; west_rtag_in = '0; west_rerr_in = '0;
    endtask

    task automatic set_rd(input int l, input logic v, input logic [BLK_W-1:0] b,
                          input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
        west_rd_vld_in[l] = v;
        west_rd_blk_in[l*BLK_W +: BLK_W] = b;
        west_rd_addr_in[l*ADDR_W +: ADDR_W] = a;
        west_rd_tag_in[l*TAG_W +: TAG_W] = t;
    endtask

    task automatic set_wr(input int l, input logic v, input logic [BLK_W-1:0] b, input logic [ADDR_W-1:0] a);
        east_wr_vld_in[l] = v;
        east_wr_blk_in[l*BLK_W +: BLK_W] = b;
        east_wr_addr_in[l*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wdata(input int l, input logic v, input logic [DATA_W-1:0] d);
        east_wdata_vld_in[l] = v;
        east_wdata_in[l*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_ring(input int l, input logic v, input logic [DATA_W-1:0] d,
                            input logic [TAG_W-1:0] t, input logic e);
        west_rdata_vld_in[l] = v;
        west_rdata_in[l*DATA_W +: DATA_W] = d;
        west_rtag_in[l*TAG_W +: TAG_W] = t;
        west_rerr_in[l] = e;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        checks++; if (east_rdata_vld_out !== '0) begin errors++; $display("FAIL reset_ring_vld: got %h required 00", east_rdata_vld_out); end
        checks++; if (par_err_out !== '0) begin errors++; $display("FAIL reset_par_err: got %h required 00", par_err_out); end
        checks++; if (west_rd_rdy_out !== 8'hFF) begin errors++; $display("FAIL reset_rdy: got %h required ff", west_rd_rdy_out); end
        checks++; if (east_rd_vld_out !== '0) begin errors++; $display("FAIL reset_fwd_vld: got %h required 00", east_rd_vld_out); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (west_rd_rdy_out !== 8'hFF) begin errors++; $display("FAIL release_rdy: got %h required ff", west_rd_rdy_out); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_write_read();
        step(); set_wr(0, 1'b1, 4'h0, 8'h05);
        @(negedge clk);
        checks++; if (west_wr_vld_out[0] !== 1'b0) begin errors++; $display("FAIL wr_hit_not_fwd: got %b required 0", west_wr_vld_out[0]); end
        step(); set_wr(0, 1'b0, 4'h0, 8'h00); set_wdata(0, 1'b1, 32'hDEADBEEF); set_rd(0, 1'b1, 4'h0, 8'h05, 12'h123);
        @(negedge clk);
        checks++; if (west_rd_rdy_out[0] !== 1'b0) begin errors++; $display("FAIL rd_after_wr_refused: got %b required 0", west_rd_rdy_out[0]); end
        checks++; if (west_wdata_vld_out[0] !== 1'b1 || west_wdata_out[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wdata_fwd: got %b/%h required 1/deadbeef", west_wdata_vld_out[0], west_wdata_out[31:0]);
        end
        step(); set_wdata(0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (west_rd_rdy_out[0] !== 1'b1) begin errors++; $display("FAIL rd_t2_rdy: got %b required 1", west_rd_rdy_out[0]); end
        checks++; if (east_rd_vld_out[0] !== 1'b0) begin errors++; $display("FAIL hit_not_fwd: got %b required 0", east_rd_vld_out[0]); end
        step(); set_rd(0, 1'b0, 4'h0, 8'h00, 12'h000);
        @(negedge clk);
        checks++; if (east_rdata_vld_out !== 8'h01) begin errors++; $display("FAIL wr_rd_vld: got %h required 01", east_rdata_vld_out); end
        checks++; if (east_rdata_out[31:0] !== 32'hDEADBEEF || east_rtag_out[11:0] !== 12'h123 || east_rerr_out[0] !== 1'b0) begin
            errors++; $display("FAIL wr_rd_data: got %h/%h/%b required deadbeef/123/0", east_rdata_out[31:0], east_rtag_out[11:0], east_rerr_out[0]);
        end
        step();
        @(negedge clk);
        checks++; if (east_rdata_vld_out !== 8'h00) begin errors++; $display("FAIL wr_rd_single: got %h required 00", east_rdata_vld_out); end
        $display("test_write_read done: errors=%0d", errors);
    endtask

    task automatic test_forward();
        step();
        set_rd(2, 1'b1, 4'h3, 8'h44, 12'hABC); east_rd_rdy_in[2] = 1'b0;
        set_wr(3, 1'b1, 4'h5, 8'h12);
        set_ring(4, 1'b1, 32'h11112222, 12'h055, 1'b1);
        @(negedge clk);
        checks++; if (east_rd_vld_out !== 8'h04) begin errors++; $display("FAIL fwd_rd_vld: got %h required 04", east_rd_vld_out); end
        checks++; if (east_rd_addr_out[23:16] !== 8'h44 || east_rd_blk_out[11:8] !== 4'h3 || east_rd_tag_out[35:24] !== 12'hABC) begin
            errors++; $display("FAIL fwd_rd_fields: got %h/%h/%h required 44/3/abc", east_rd_addr_out[23:16], east_rd_blk_out[11:8], east_rd_tag_out[35:24]);
        end
        checks++; if (west_rd_rdy_out[2] !== 1'b0) begin errors++; $display("FAIL fwd_rdy_low: got %b required 0", west_rd_rdy_out[2]); end
        checks++; if (west_wr_vld_out !== 8'h08 || west_wr_addr_out[31:24] !== 8'h12 || west_wr_blk_out[15:12] !== 4'h5) begin
            errors++; $display("FAIL fwd_wr: got %h/%h/%h required 08/12/5", west_wr_vld_out, west_wr_addr_out[31:24], west_wr_blk_out[15:12]);
        end
        checks++; if (east_rdata_vld_out !== 8'h10 || east_rdata_out[159:128] !== 32'h11112222 ||
                      east_rtag_out[59:48] !== 12'h055 || east_rerr_out !== 8'h10) begin
            errors++; $display("FAIL ring_pass: got %h/%h/%h/%h required 10/11112222/055/10",
                               east_rdata_vld_out, east_rdata_out[159:128], east_rtag_out[59:48], east_rerr_out);
        end
        step(); east_rd_rdy_in[2] = 1'b1;
        @(negedge clk);
        checks++; if (west_rd_rdy_out[2] !== 1'b1) begin errors++; $display("FAIL fwd_rdy_high: got %b required 1", west_rd_rdy_out[2]); end
        step(); clear_inputs();
        @(negedge clk);
        checks++; if (east_rdata_vld_out !== 8'h00) begin errors++; $display("FAIL fwd_no_local: got %h required 00", east_rdata_vld_out); end
        $display("test_forward done: errors=%0d", errors);
    endtask

    task automatic test_back_to_back();
        step(); set_wr(1, 1'b1, 4'h0, 8'h10);
        step(); set_wr(1, 1'b1, 4'h0, 8'h11); set_wdata(1, 1'b1, 32'h01234567);
        step(); set_wr(1, 1'b0, 4'h0, 8'h00); set_wdata(1, 1'b1, 32'h89ABCDEF);
        @(negedge clk);
        checks++; if (west_rd_rdy_out[1] !== 1'b0) begin errors++; $display("FAIL b2b_wr_block: got %b required 0", west_rd_rdy_out[1]); end
        step(); set_wdata(1, 1'b0, 32'h0); set_rd(1, 1'b1, 4'h0, 8'h10, 12'h301);
        @(negedge clk);
        checks++; if (west_rd_rdy_out[1] !== 1'b1) begin errors++; $display("FAIL b2b_rdy0: got %b required 1", west_rd_rdy_out[1]); end
        step(); set_rd(1, 1'b1, 4'h0, 8'h11, 12'h302);
        @(negedge clk);
        checks++; if (west_rd_rdy_out[1] !== 1'b1) begin errors++; $display("FAIL b2b_rdy1: got %b required 1", west_rd_rdy_out[1]); end
        checks++; if (east_rdata_vld_out[1] !== 1'b1 || east_rdata_out[63:32] !== 32'h01234567 || east_rtag_out[23:12] !== 12'h301) begin
            errors++; $display("FAIL b2b_first: got %b/%h/%h required 1/01234567/301", east_rdata_vld_out[1], east_rdata_out[63:32], east_rtag_out[23:12]);
        end
        step(); set_rd(1, 1'b0, 4'h0, 8'h00, 12'h000);
        @(negedge clk);
        checks++; if (east_rdata_vld_out[1] !== 1'b1 || east_rdata_out[63:32] !== 32'h89ABCDEF || east_rtag_out[23:12] !== 12'h302) begin
            errors++; $display("FAIL b2b_second: got %b/%h/%h required 1/89abcdef/302", east_rdata_vld_out[1], east_rdata_out[63:32], east_rtag_out[23:12]);
        end
        step();
        @(negedge clk);
        checks++; if (east_rdata_vld_out[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b required 0", east_rdata_vld_out[1]); end
        $display("test_back_to_back done: errors=%0d", errors);
    endtask

    task automatic test_skid();
        logic [TAG_W-1:0] up_tag;
        step(); set_wr(0, 1'b1, 4'h0, 8'h06);
        step(); set_wr(0, 1'b0, 4'h0, 8'h00); set_wdata(0, 1'b1, 32'hCAFEF00D);
        step(); set_wdata(0, 1'b0, 32'h0);
        for (int k = 0; k < 9; k++) begin
            step();
            up_tag = 12'h800 + TAG_W'(k);
            if (k < 6) set_ring(0, 1'b1, 32'hA0A0A000 + DATA_W'(k), up_tag, 1'b0);
            else       set_ring(0, 1'b0, 32'h0, 12'h000, 1'b0);
            case (k)
                0: set_rd(0, 1'b1, 4'h0, 8'h05, 12'h201);
                1: set_rd(0, 1'b1, 4'h0, 8'h06, 12'h202);
                2: set_rd(0, 1'b1, 4'h0, 8'h05, 12'h203);
                4: set_rd(0, 1'b0, 4'h0, 8'h00, 12'h000);
                default: ;
            endcase
            @(negedge clk);
            if (k < 2) begin
                checks++; if (west_rd_rdy_out[0] !== 1'b1) begin errors++; $display("FAIL skid_rdy_k%0d: got %b required 1", k, west_rd_rdy_out[0]); end
            end else if (k < 4) begin
                checks++; if (west_rd_rdy_out[0] !== 1'b0) begin errors++; $display("FAIL skid_full_k%0d: got %b required 0", k, west_rd_rdy_out[0]); end
            end
            if (k < 6) begin
                checks++; if (east_rdata_vld_out[0] !== 1'b1 || east_rtag_out[11:0] !== up_tag) begin
                    errors++; $display("FAIL skid_up_k%0d: got %b/%h required 1/%h", k, east_rdata_vld_out[0], east_rtag_out[11:0], up_tag);
                end
            end else if (k == 6) begin
                checks++; if (east_rdata_vld_out[0] !== 1'b1 || east_rdata_out[31:0] !== 32'hDEADBEEF || east_rtag_out[11:0] !== 12'h201) begin
                    errors++; $display("FAIL skid_pop0: got %b/%h/%h required 1/deadbeef/201", east_rdata_vld_out[0], east_rdata_out[31:0], east_rtag_out[11:0]);
                end
            end else if (k == 7) begin
                checks++; if (east_rdata_vld_out[0] !== 1'b1 || east_rdata_out[31:0] !== 32'hCAFEF00D || east_rtag_out[11:0] !== 12'h202) begin
                    errors++; $display("FAIL skid_pop1: got %b/%h/%h required 1/cafef00d/202", east_rdata_vld_out[0], east_rdata_out[31:0], east_rtag_out[11:0]);
                end
            end else begin
                checks++; if (east_rdata_vld_out[0] !== 1'b0 || west_rd_rdy_out[0] !== 1'b1) begin
                    errors++; $display("FAIL skid_drained: got vld %b rdy %b required 0/1", east_rdata_vld_out[0], west_rd_rdy_out[0]);
                end
            end
        end
        $display("test_skid done: errors=%0d", errors);
    endtask

    task automatic test_reset_midflight();
        step(); set_ring(0, 1'b1, 32'h55555555, 12'h777, 1'b0); set_rd(0, 1'b1, 4'h0, 8'h05, 12'h401);
        step(); set_rd(0, 1'b1, 4'h0, 8'h06, 12'h402);
        step(); rst = 1'b1; clear_inputs();
        @(negedge clk);
        checks++; if (west_rd_rdy_out[0] !== 1'b1 || east_rdata_vld_out !== 8'h00) begin
            errors++; $display("FAIL midrst_state: got rdy %b vld %h required 1/00", west_rd_rdy_out[0], east_rdata_vld_out);
        end
        step(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (east_rdata_vld_out !== 8'h00 || west_rd_rdy_out[0] !== 1'b1) begin
                errors++; $display("FAIL midrst_stale_c%0d: got vld %h rdy %b required 00/1", k, east_rdata_vld_out, west_rd_rdy_out[0]);
            end
            step();
        end
        set_rd(0, 1'b1, 4'h0, 8'h05, 12'h405);
        step(); set_rd(0, 1'b0, 4'h0, 8'h00, 12'h000);
        @(negedge clk);
        checks++; if (east_rdata_vld_out[0] !== 1'b1 || east_rdata_out[31:0] !== 32'hDEADBEEF || east_rtag_out[11:0] !== 12'h405) begin
            errors++; $display("FAIL midrst_sram_kept: got %b/%h/%h required 1/deadbeef/405", east_rdata_vld_out[0], east_rdata_out[31:0], east_rtag_out[11:0]);
        end
        $display("test_reset_midflight done: errors=%0d", errors);
    endtask

    task automatic test_parity();
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
        step(); set_wr(5, 1'b1, 4'h0, 8'h20);
        step(); set_wr(5, 1'b0, 4'h0, 8'h00); set_wdata(5, 1'b1, 32'h0000000F);
        step(); set_wdata(5, 1'b0, 32'h0);
`ifdef VEC_CACHE_MEM_PARITY_EN
        dut.g_lane[5].u_sram.mem_q[8'h20][0] = 1'b0;
        exp_data = 32'h0000000E;
        exp_err  = 1'b1;
`else
        exp_data = 32'h0000000F;
        exp_err  = 1'b0;
`endif
        set_rd(5, 1'b1, 4'h0, 8'h20, 12'h5A5);
        step(); set_rd(5, 1'b0, 4'h0, 8'h00, 12'h000);
        @(negedge clk);
        checks++; if (east_rdata_vld_out[5] !== 1'b1 || east_rdata_out[191:160] !== exp_data || east_rtag_out[71:60] !== 12'h5A5) begin
            errors++; $display("FAIL par_read: got %b/%h/%h required 1/%h/5a5", east_rdata_vld_out[5], east_rdata_out[191:160], east_rtag_out[71:60], exp_data);
        end
        checks++; if (east_rerr_out[5] !== exp_err) begin errors++; $display("FAIL par_rerr: got %b required %b", east_rerr_out[5], exp_err); end
        step(); step();
        @(negedge clk);
        checks++; if (par_err_out !== {2'b00, exp_err, 5'b00000}) begin
            errors++; $display("FAIL par_sticky: got %h required %h", par_err_out, {2'b00, exp_err, 5'b00000});
        end
        step(); rst = 1'b1;
        @(negedge clk);
        checks++; if (par_err_out !== 8'h00) begin errors++; $display("FAIL par_clear: got %h required 00", par_err_out); end
        step(); rst = 1'b0;
        $display("test_parity done: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_back_to_back();
        test_skid();
        test_reset_midflight();
        test_parity();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
